// File: rtl/apb_pkg.sv
// Shared APB types and default widths for the APB requester and its slaves.
package apb_pkg;
  localparam int APB_ADDR_WIDTH = 1;
  localparam int APB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  typedef struct packed {
    logic [APB_DATA_WIDTH-1:0] rdata;
    logic                      err;
  } apb_rsp_t;
endpackage

// File: rtl/apb_master.sv
// APB3 requester: valid/ready command in, SETUP/ACCESS transfer out, one-entry
// response slot back, with a bounded PREADY wait so a hung slave cannot stall us.
module apb_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic                  PREADY,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PSLVERR
);
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  apb_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  rsp_valid_q, rsp_valid_d;
  apb_rsp_t              rsp_q, rsp_d;
  logic                  accept, timeout;

  assign accept  = req_valid && req_ready;
  // Fires on the last permitted waiting cycle, so ACCESS lasts at most TIMEOUT_CYCLES.
  assign timeout = (TIMEOUT_CYCLES != 0) && (int'(cnt_q) == TIMEOUT_CYCLES - 1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    req_ready   = 1'b0;
    PSEL        = 1'b0;
    PENABLE     = 1'b0;
    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        // PRESETn term keeps req_ready low while reset is held.
        req_ready = PRESETn && (!rsp_valid_q || rsp_ready);
        if (req_valid && req_ready) state_d = SETUP;
      end
      SETUP: begin
        PSEL    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          rsp_valid_d = 1'b1;
          rsp_d.err   = PSLVERR;
          rsp_d.rdata = PWRITE ? '0 : APB_DATA_WIDTH'(PRDATA);
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (timeout) begin
          rsp_valid_d = 1'b1;
          rsp_d.err   = 1'b1;
          rsp_d.rdata = '0;
          cnt_d       = '0;
          state_d     = IDLE;
        end else if (TIMEOUT_CYCLES != 0 && cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      if (accept) begin
        addr_q  <= req_addr;
        write_q <= req_write;
        wdata_q <= req_wdata;
      end
    end
  end

  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_q.rdata[DATA_WIDTH-1:0];
  assign rsp_err   = rsp_q.err;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench: apb_master driving a one-register slave model with programmable wait states.
module tb_apb_master;
  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [0:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_rdata;
  logic [0:0]  PADDR;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PWDATA, PRDATA;

  int checks = 0;
  int errors = 0;

  // slave model: register at address 0, address 1 answers with PSLVERR
  int          wait_n = 0;
  int          acc_cnt = 0;
  logic [31:0] sreg = '0;

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_WIDTH(1), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  assign PREADY  = PSEL && PENABLE && (acc_cnt >= wait_n);
  assign PSLVERR = PSEL && PENABLE && (PADDR != 1'b0);
  assign PRDATA  = (PADDR == 1'b0) ? sreg : 32'h0;

  always @(posedge PCLK) begin
    acc_cnt <= (PSEL && PENABLE) ? acc_cnt + 1 : 0;
    if (PSEL && PENABLE && PREADY && PWRITE && PADDR == 1'b0) sreg <= PWDATA;
  end

  typedef struct {
    logic        wr;
    logic [0:0]  addr;
    logic [31:0] wdata;
    int          wait_n;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_acc;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    bit done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge PCLK);
      if (rsp_valid) done = 1'b1;
    end
    chk({tag, " rsp_seen"}, 32'(done), 32'd1);
  endtask

  task automatic pop_rsp(input string tag);
    @(posedge PCLK); #1 rsp_ready = 1'b1;
    @(posedge PCLK); #1 rsp_ready = 1'b0;
    @(negedge PCLK);
    chk({tag, " rsp_popped"}, 32'(rsp_valid), 32'd0);
  endtask

  task automatic run_xfer(input vec_t v, input string tag);
    int  k = 0;
    int  acc = 0;
    bit  stable = 1'b1;
    bit  done = 1'b0;
    wait_n = v.wait_n;
    @(posedge PCLK); #1;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    rsp_ready = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      @(negedge PCLK);
      if (req_ready) done = 1'b1;
    end
    chk({tag, " accept"}, 32'(done), 32'd1);
    @(posedge PCLK); #1 req_valid = 1'b0;
    done = 1'b0;
    while (!done && k < 40) begin
      @(negedge PCLK);
      k++;
      if (rsp_valid) done = 1'b1;
      else begin
        if (PSEL && PENABLE) acc++;
        if (PSEL && (PADDR !== v.addr || PWRITE !== v.wr || PWDATA !== v.wdata)) stable = 1'b0;
      end
    end
    chk({tag, " rsp_seen"}, 32'(done), 32'd1);
    chk({tag, " latency"}, 32'(k), 32'(v.exp_acc + 2));
    chk({tag, " access_cycles"}, 32'(acc), 32'(v.exp_acc));
    chk({tag, " apb_stable"}, 32'(stable), 32'd1);
    chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.exp_err));
    chk({tag, " rsp_rdata"}, rsp_rdata, v.exp_rdata);
    chk({tag, " psel_after"}, 32'(PSEL), 32'd0);
    pop_rsp(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //         wr    addr  wdata          wait err   rdata          acc
    vecs[0] = '{1'b1, 1'b0, 32'hDEADBEEF,  0,  1'b0, 32'h0,          1};
    vecs[1] = '{1'b0, 1'b0, 32'h0,         0,  1'b0, 32'hDEADBEEF,   1};
    vecs[2] = '{1'b0, 1'b1, 32'h0,         0,  1'b1, 32'h0,          1};
    vecs[3] = '{1'b1, 1'b0, 32'h12345678,  3,  1'b0, 32'h0,          4};
    vecs[4] = '{1'b0, 1'b0, 32'h5A5A5A5A,  3,  1'b0, 32'h12345678,   4};
    vecs[5] = '{1'b1, 1'b1, 32'hFFFFFFFF,  1,  1'b1, 32'h0,          2};
    vecs[6] = '{1'b0, 1'b0, 32'h0,         255, 1'b1, 32'h0,         16};
    vecs[7] = '{1'b0, 1'b0, 32'h0,         15, 1'b0, 32'h12345678,  16};

    // reset state
    repeat (2) @(negedge PCLK);
    chk("rst psel", 32'(PSEL), 32'd0);
    chk("rst penable", 32'(PENABLE), 32'd0);
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    chk("rst paddr_pwdata", {31'(PWDATA), PADDR}, 32'd0);
    @(posedge PCLK); #1 PRESETn = 1'b1;
    @(negedge PCLK);
    chk("rel req_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 8; i++) run_xfer(vecs[i], $sformatf("vec%0d", i));

    // backpressure: response held, new command waits until the slot frees
    wait_n = 0;
    @(posedge PCLK); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 1'b0; rsp_ready = 1'b0;
    @(negedge PCLK);
    chk("bp first accept", 32'(req_ready), 32'd1);
    @(posedge PCLK); #1;
    req_write = 1'b1; req_wdata = 32'hCAFEF00D;
    wait_rsp("bp read");
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      chk($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
      chk($sformatf("bp hold%0d rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp hold%0d rsp_rdata", i), rsp_rdata, 32'h12345678);
    end
    @(posedge PCLK); #1 rsp_ready = 1'b1;
    @(negedge PCLK);
    chk("bp free req_ready", 32'(req_ready), 32'd1);
    @(posedge PCLK); #1 rsp_ready = 1'b0; req_valid = 1'b0;
    @(negedge PCLK);
    chk("bp setup psel", 32'(PSEL), 32'd1);
    chk("bp setup penable", 32'(PENABLE), 32'd0);
    chk("bp setup rsp_valid", 32'(rsp_valid), 32'd0);
    chk("bp setup pwdata", PWDATA, 32'hCAFEF00D);
    wait_rsp("bp write");
    chk("bp write err", 32'(rsp_err), 32'd0);
    pop_rsp("bp write");
    run_xfer('{1'b0, 1'b0, 32'h0, 0, 1'b0, 32'hCAFEF00D, 1}, "bp readback");

    // reset pulse in the middle of ACCESS
    wait_n = 5;
    @(posedge PCLK); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 1'b0;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge PCLK);
        if (PSEL && PENABLE) seen = 1'b1;
        else if (PSEL) req_valid = 1'b0;
      end
      chk("rstmid in_access", 32'(seen), 32'd1);
    end
    req_valid = 1'b0;
    #2 PRESETn = 1'b0;
    #1;
    chk("rstmid psel", 32'(PSEL), 32'd0);
    chk("rstmid penable", 32'(PENABLE), 32'd0);
    chk("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge PCLK); #1 PRESETn = 1'b1;
    run_xfer('{1'b1, 1'b0, 32'h0BADCAFE, 0, 1'b0, 32'h0, 1}, "post_rst write");
    run_xfer('{1'b0, 1'b0, 32'h0, 2, 1'b0, 32'h0BADCAFE, 3}, "post_rst read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
